mcpu_ctrl: RTL and testbench

MCPU_CTRL -- requirements
Module: mcpu_ctrl

---
 rtl/mcpu_pkg.sv | 63 ++++++
 rtl/mcpu_aludec.sv | 43 ++++
 rtl/mcpu_ctrl.sv | 157 +++++++++++++++
 tb/tb_mcpu_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcpu_pkg.sv
// Shared definitions for the multi-cycle CPU controller: state codes,
// ALU operation codes, opcode and funct constants.
package mcpu_pkg;

  typedef enum logic [3:0] {
    ST_IF  = 4'd0,
    ST_ID  = 4'd1,
    ST_MA  = 4'd2,
    ST_MRD = 4'd3,
    ST_MWB = 4'd4,
    ST_MWR = 4'd5,
    ST_REX = 4'd6,
    ST_RWB = 4'd7,
    ST_BR  = 4'd8,
    ST_J   = 4'd9,
    ST_IEX = 4'd10,
    ST_IWB = 4'd11,
    ST_JAL = 4'd12,
    ST_JR  = 4'd13
  } state_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  // An R-type funct outside this set executes as ADD but must not write back.
  function automatic logic rfun_known(input logic [5:0] fun);
    case (fun)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR,
      FN_NOR, FN_SLT, FN_SRL: rfun_known = 1'b1;
      default:                rfun_known = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mcpu_aludec.sv
// Combinational ALU operation decode from the controller state and the
// instruction opcode/funct fields.
module mcpu_aludec
  import mcpu_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic [5:0] fun,
  output logic [2:0] alu_op
);

  always_comb begin
    alu_op = ALU_AND;
    case (state)
      ST_IF, ST_ID, ST_MA, ST_JR: alu_op = ALU_ADD;
      ST_BR:                      alu_op = ALU_SUB;
      ST_REX: begin
        case (fun)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SRL:  alu_op = ALU_SRL;
          default: alu_op = ALU_ADD;
        endcase
      end
      ST_IEX: begin
        case (opcode)
          OP_ANDI: alu_op = ALU_AND;
          OP_ORI:  alu_op = ALU_OR;
          OP_XORI: alu_op = ALU_XOR;
          OP_SLTI: alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
      end
      default: alu_op = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mcpu_ctrl.sv
// Multi-cycle MIPS-style controller: Moore FSM over the datapath, with
// Mealy IRWrite/PCWrite in fetch and PCWrite in branch.
module mcpu_ctrl
  import mcpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] OPcode,
  input  logic [5:0] Fun,
  input  logic       zero,
  input  logic       MIO_ready,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       PCWrite,
  output logic       CPU_MIO,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] ALU_operation,
  output logic [3:0] state_out
);

  state_t state, state_nx;
  logic   rwb_en;

  // rwb_en captures in REX whether the funct is a real op, so RWB stays a
  // pure function of registered state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IF;
      rwb_en <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == ST_REX) rwb_en <= rfun_known(Fun);
    end
  end

  always_comb begin
    state_nx = state;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    PCWrite  = 1'b0;
    CPU_MIO  = 1'b0;
    RegDst   = 2'b00;
    MemtoReg = 2'b00;
    ALUSrcA  = 2'b00;
    ALUSrcB  = 2'b00;
    PCSource = 2'b00;
    case (state)
      ST_IF: begin
        MemRead = 1'b1;
        CPU_MIO = 1'b1;
        ALUSrcB = 2'b01;
        // Gated by rst_n so the fetch strobes stay low while reset is held.
        IRWrite = MIO_ready & rst_n;
        PCWrite = MIO_ready & rst_n;
        if (MIO_ready) state_nx = ST_ID;
      end
      ST_ID: begin
        ALUSrcB = 2'b11;
        case (OPcode)
          OP_RTYPE:                state_nx = (Fun == FN_JR) ? ST_JR : ST_REX;
          OP_LW, OP_SW:            state_nx = ST_MA;
          OP_BEQ, OP_BNE:          state_nx = ST_BR;
          OP_J:                    state_nx = ST_J;
          OP_JAL:                  state_nx = ST_JAL;
          OP_ADDI, OP_ANDI, OP_ORI,
          OP_XORI, OP_SLTI:        state_nx = ST_IEX;
          default:                 state_nx = ST_IF;
        endcase
      end
      ST_MA: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        state_nx = (OPcode == OP_SW) ? ST_MWR : ST_MRD;
      end
      ST_MRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        CPU_MIO = 1'b1;
        if (MIO_ready) state_nx = ST_MWB;
      end
      ST_MWB: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b01;
        state_nx = ST_IF;
      end
      ST_MWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        CPU_MIO  = 1'b1;
        if (MIO_ready) state_nx = ST_IF;
      end
      ST_REX: begin
        ALUSrcA  = (Fun == FN_SRL) ? 2'b10 : 2'b01;
        state_nx = ST_RWB;
      end
      ST_RWB: begin
        RegWrite = rwb_en;
        RegDst   = 2'b01;
        state_nx = ST_IF;
      end
      ST_BR: begin
        ALUSrcA  = 2'b01;
        PCSource = 2'b01;
        PCWrite  = (OPcode == OP_BNE) ? ~zero : zero;
        state_nx = ST_IF;
      end
      ST_J: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
        state_nx = ST_IF;
      end
      ST_IEX: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        state_nx = ST_IWB;
      end
      ST_IWB: begin
        RegWrite = 1'b1;
        state_nx = ST_IF;
      end
      ST_JAL: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
        RegWrite = 1'b1;
        RegDst   = 2'b10;
        MemtoReg = 2'b10;
        state_nx = ST_IF;
      end
      ST_JR: begin
        ALUSrcA  = 2'b01;
        PCWrite  = 1'b1;
        state_nx = ST_IF;
      end
      default: state_nx = ST_IF;
    endcase
  end

  mcpu_aludec u_aludec (
    .state  (state),
    .opcode (OPcode),
    .fun    (Fun),
    .alu_op (ALU_operation)
  );

  assign state_out = state;

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Self-checking bench for mcpu_ctrl: per-instruction state paths and output
// vectors predicted from instruction class, plus reset scenarios.
module tb_mcpu_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] OPcode, Fun;
  logic       zero, MIO_ready;
  logic       MemRead, MemWrite, IorD, IRWrite, RegWrite, PCWrite, CPU_MIO;
  logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
  logic [2:0] ALU_operation;
  logic [3:0] state_out;

  int n_tests = 0;
  int n_fail  = 0;

  int st_q[$];
  bit rdy_q[$];

  mcpu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .OPcode(OPcode), .Fun(Fun), .zero(zero),
    .MIO_ready(MIO_ready), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .PCWrite(PCWrite), .CPU_MIO(CPU_MIO),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .ALU_operation(ALU_operation), .state_out(state_out)
  );

  always #5 clk = ~clk;

  wire [19:0] obs = {MemRead, MemWrite, IorD, IRWrite, RegWrite, PCWrite, CPU_MIO,
                     RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALU_operation};

  function automatic logic [2:0] ref_alu_r(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b100110: return 3'b011;
      6'b100111: return 3'b100;
      6'b101010: return 3'b111;
      6'b000010: return 3'b101;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic bit ref_fun_known(input logic [5:0] f);
    return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                     6'b100110, 6'b100111, 6'b101010, 6'b000010};
  endfunction

  function automatic logic [2:0] ref_alu_i(input logic [5:0] op);
    case (op)
      6'b001100: return 3'b000;
      6'b001101: return 3'b001;
      6'b001110: return 3'b011;
      6'b001010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected output vector for one cycle, straight from the per-state table.
  function automatic logic [19:0] exp_out(input int st, input logic [5:0] op,
                                          input logic [5:0] f, input logic z,
                                          input bit rdy);
    logic mr = 0, mw = 0, iord = 0, irw = 0, rw = 0, pcw = 0, mio = 0;
    logic [1:0] rd = 0, m2r = 0, sa = 0, sb = 0, ps = 0;
    logic [2:0] alu = 0;
    case (st)
      0:  begin mr = 1; mio = 1; sb = 2'b01; alu = 3'b010; irw = rdy; pcw = rdy; end
      1:  begin sb = 2'b11; alu = 3'b010; end
      2:  begin sa = 2'b01; sb = 2'b10; alu = 3'b010; end
      3:  begin mr = 1; iord = 1; mio = 1; end
      4:  begin rw = 1; m2r = 2'b01; end
      5:  begin mw = 1; iord = 1; mio = 1; end
      6:  begin sa = (f == 6'b000010) ? 2'b10 : 2'b01; alu = ref_alu_r(f); end
      7:  begin rw = ref_fun_known(f); rd = 2'b01; end
      8:  begin sa = 2'b01; alu = 3'b110; ps = 2'b01; pcw = (op == 6'b000101) ? ~z : z; end
      9:  begin ps = 2'b10; pcw = 1; end
      10: begin sa = 2'b01; sb = 2'b10; alu = ref_alu_i(op); end
      11: begin rw = 1; end
      12: begin ps = 2'b10; pcw = 1; rw = 1; rd = 2'b10; m2r = 2'b10; end
      13: begin sa = 2'b01; alu = 3'b010; pcw = 1; end
      default: ;
    endcase
    return {mr, mw, iord, irw, rw, pcw, mio, rd, m2r, sa, sb, ps, alu};
  endfunction

  function automatic void push_st(input int s, input bit r);
    st_q.push_back(s);
    rdy_q.push_back(r);
  endfunction

  function automatic bit rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Builds the expected state path from the instruction class, then drives
  // and checks it cycle by cycle. Entered just after a rising edge in IF.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input logic z,
                           input int if_wait, input int mem_wait, input string name);
    logic [19:0] expv;
    st_q.delete();
    rdy_q.delete();
    for (int i = 0; i < if_wait; i++) push_st(0, 1'b0);
    push_st(0, 1'b1);
    push_st(1, rnd_bit());
    if (op == 6'b000000) begin
      if (f == 6'b001000) push_st(13, rnd_bit());
      else begin push_st(6, rnd_bit()); push_st(7, rnd_bit()); end
    end else if (op == 6'b100011) begin
      push_st(2, rnd_bit());
      for (int i = 0; i < mem_wait; i++) push_st(3, 1'b0);
      push_st(3, 1'b1);
      push_st(4, rnd_bit());
    end else if (op == 6'b101011) begin
      push_st(2, rnd_bit());
      for (int i = 0; i < mem_wait; i++) push_st(5, 1'b0);
      push_st(5, 1'b1);
    end else if (op == 6'b000100 || op == 6'b000101) push_st(8, rnd_bit());
    else if (op == 6'b000010) push_st(9, rnd_bit());
    else if (op == 6'b000011) push_st(12, rnd_bit());
    else if (op inside {6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010}) begin
      push_st(10, rnd_bit());
      push_st(11, rnd_bit());
    end
    for (int i = 0; i < st_q.size(); i++) begin
      OPcode = op; Fun = f; zero = z; MIO_ready = rdy_q[i];
      @(negedge clk);
      expv = exp_out(st_q[i], op, f, z, rdy_q[i]);
      n_tests++;
      if (state_out !== 4'(st_q[i])) begin
        n_fail++;
        $display("FAIL %s cyc%0d state_out got %0d want %0d", name, i, state_out, st_q[i]);
      end
      n_tests++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL %s cyc%0d outputs got %b want %b", name, i, obs, expv);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; OPcode = 6'b100011; Fun = 6'b0; zero = 1'b0; MIO_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (state_out !== 4'd0) begin n_fail++; $display("FAIL reset_async state_out got %0d want 0", state_out); end
    n_tests++;
    if (MemRead !== 1'b1 || PCWrite !== 1'b0 || IRWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async MemRead/PCWrite/IRWrite got %b%b%b want 100", MemRead, PCWrite, IRWrite);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (obs !== exp_out(0, OPcode, Fun, zero, 1'b0)) begin
      n_fail++;
      $display("FAIL reset_held outputs got %b want %b", obs, exp_out(0, OPcode, Fun, zero, 1'b0));
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    logic [5:0] funs [10] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                             6'b100111, 6'b101010, 6'b000010, 6'b111111, 6'b000000};
    for (int i = 0; i < 10; i++) run_instr(6'b000000, funs[i], 1'b0, 0, 0, "rtype");
  endtask

  task automatic test_lw_wait();
    run_instr(6'b100011, 6'b0, 1'b0, 0, 3, "lw_wait3");
    run_instr(6'b100011, 6'b0, 1'b0, 2, 0, "lw_ifwait");
  endtask

  task automatic test_sw();
    run_instr(6'b101011, 6'b0, 1'b0, 0, 0, "sw");
    run_instr(6'b101011, 6'b0, 1'b1, 1, 2, "sw_wait");
  endtask

  task automatic test_branch();
    run_instr(6'b000100, 6'b0, 1'b1, 0, 0, "beq_z1");
    run_instr(6'b000100, 6'b0, 1'b0, 0, 0, "beq_z0");
    run_instr(6'b000101, 6'b0, 1'b0, 0, 0, "bne_z0");
    run_instr(6'b000101, 6'b0, 1'b1, 0, 0, "bne_z1");
  endtask

  task automatic test_itype();
    logic [5:0] ops [5] = '{6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010};
    for (int i = 0; i < 5; i++) run_instr(ops[i], 6'($urandom), 1'b0, 0, 0, "itype");
  endtask

  task automatic test_jumps();
    run_instr(6'b000010, 6'b0, 1'b0, 0, 0, "j");
    run_instr(6'b000011, 6'b0, 1'b0, 0, 0, "jal");
    run_instr(6'b000000, 6'b001000, 1'b0, 0, 0, "jr");
  endtask

  task automatic test_illegal();
    run_instr(6'b111111, 6'b0, 1'b0, 0, 0, "illegal");
    MIO_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (state_out !== 4'd0 || RegWrite !== 1'b0 || MemWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_after state/RegWrite/MemWrite got %0d/%b/%b want 0/0/0",
               state_out, RegWrite, MemWrite);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    OPcode = 6'b101011; Fun = 6'b0; zero = 1'b0; MIO_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    MIO_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (state_out !== 4'd5 || MemWrite !== 1'b1) begin
      n_fail++;
      $display("FAIL mwr_reach state/MemWrite got %0d/%b want 5/1", state_out, MemWrite);
    end
    #2 rst_n = 1'b0; MIO_ready = 1'b1;
    #1;
    n_tests++;
    if (state_out !== 4'd0 || MemWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL mwr_reset state/MemWrite got %0d/%b want 0/0", state_out, MemWrite);
    end
    n_tests++;
    if (obs !== exp_out(0, OPcode, Fun, zero, 1'b0)) begin
      n_fail++;
      $display("FAIL mwr_reset outputs got %b want %b", obs, exp_out(0, OPcode, Fun, zero, 1'b0));
    end
    @(posedge clk); #1 rst_n = 1'b1; MIO_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (state_out !== 4'd0 || MemWrite !== 1'b0 || RegWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL mwr_after state/MemWrite/RegWrite got %0d/%b/%b want 0/0/0",
               state_out, MemWrite, RegWrite);
    end
    @(posedge clk); #1;
    run_instr(6'b100011, 6'b0, 1'b0, 0, 1, "lw_after_reset");
  endtask

  task automatic test_random();
    logic [5:0] ops [14] = '{6'b000000, 6'b000000, 6'b100011, 6'b101011, 6'b000100,
                            6'b000101, 6'b000010, 6'b000011, 6'b001000, 6'b001100,
                            6'b001101, 6'b001110, 6'b001010, 6'b111111};
    logic [5:0] funs [10] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                             6'b100111, 6'b101010, 6'b000010, 6'b001000, 6'b010101};
    logic [5:0] op, f;
    for (int n = 0; n < 80; n++) begin
      op = (($urandom_range(0, 7)) == 0) ? 6'($urandom) : ops[$urandom_range(0, 13)];
      f  = (($urandom_range(0, 7)) == 0) ? 6'($urandom) : funs[$urandom_range(0, 9)];
      run_instr(op, f, rnd_bit(), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), "random");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw();
    test_branch();
    test_itype();
    test_jumps();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
